idex_skid_stage: RTL and testbench
==================================

Name: idex_skid_stage

Overview:
- Parametrised ID→EX pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Replaces the always-advance ID/EX register: adds back-pressure, flush (branch/exception kill) and stall statistics.
- Payload is an opaque packed bundle (aluop, alusel, op1, op2, waddr, we, link_addr); the same block is reusable for IF/ID and EX/MEM.
- Sits between id and ex; `in_ready` is a pure function of state flops, so there is no combinational ready path back into id.

Parameters:
WIDTH, 113, payload bits (8 aluop + 3 alusel + 32 op1 + 32 op2 + 5 waddr + 1 we + 32 link_addr)
NOP_VALUE, {WIDTH{1'b0}}, payload driven/held when stage holds a bubble (encodes EXE_NOP_OP, EXE_RES_NOP, we=0)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset rst, synchronous, active-high
flush  in  1  kill all held entries and the current input transfer
in_valid  in  1  id presents a valid instruction
in_ready  out  1  stage can accept (registered; low only in FULL)
in_data  in  WIDTH  payload from id
out_valid  out  1  ex-side entry valid
out_ready  in  1  ex consumes entry this cycle
out_data  out  WIDTH  payload to ex; NOP_VALUE when out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main register drives out_data.
  - skid register holds the overflow entry.
- State machine encodings and transitions:
  - EMPTY=2'd0: in_ready=1, out_valid=0.
    - in_fire → BUSY, main<=in_data.
  - BUSY=2'd1: in_ready=1, out_valid=1.
    - in_fire & out_fire → BUSY, main<=in_data.
    - in_fire & !out_fire → FULL, skid<=in_data.
    - !in_fire & out_fire → EMPTY, main<=NOP_VALUE.
    - otherwise hold.
  - FULL=2'd2: in_ready=0, out_valid=1.
    - out_fire → BUSY, main<=skid, skid<=NOP_VALUE.
    - otherwise hold.
  - Encoding 2'd3 is illegal → next state EMPTY.
- Latency and throughput:
  - 1 cycle in_data→out_data when unstalled.
  - Full throughput of 1 transfer/cycle in BUSY.
  - No payload is ever dropped or duplicated except by flush.
- Ordering: FIFO order is preserved; skid is always younger than main.
- Flush:
  - Priority rst > flush > handshake.
  - Next state EMPTY; main and skid <= NOP_VALUE.
  - An in_fire in the same cycle is discarded: upstream sees it accepted, and the instruction is killed.
  - stall_cnt is not modified by flush.
- Reset, including mid-operation:
  - State=EMPTY, main=skid=NOP_VALUE.
  - Outputs: out_valid=0, in_ready=1, out_data=NOP_VALUE, occupancy=0, stall_cnt=0.
- occupancy: EMPTY=0, BUSY=1, FULL=2 (from state only).
- stall_cnt:
  - +1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
- out_data may change only on out_fire, on an EMPTY→BUSY load, on flush or on rst. It is stable while out_valid & !out_ready.
- All outputs are driven from flops; there is no comb path in→out.

Decomposition:
- defines.v gains:
  - state encodings `SKID_EMPTY/`SKID_BUSY/`SKID_FULL.
  - `IdExBundleWidth 113.
  - field offset macros for packing/unpacking the bundle.
- id and ex pack/unpack at their boundaries; this block never interprets the payload.
- No sub-module: the block is itself the reusable leaf primitive. Future if_id/ex_mem instances are parameter overrides of it.

Test Plan:
- Reset: rst=1 two cycles with in_valid=1, in_data=0xAB (bench WIDTH=8) → out_valid=0, in_ready=1, out_data=0x00, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, send 0x01,0x02,0x03 back-to-back → out_data 0x01,0x02,0x03 on consecutive cycles one cycle later; occupancy stays 1; in_ready never drops.
- Back-pressure: out_ready=0, send 0x11 then 0x22 → occupancy=2, in_ready=0, out_data=0x11 stable, stall_cnt increments per cycle. Then out_ready=1 → 0x11 then 0x22 delivered, state EMPTY.
- Flush while FULL with simultaneous in_valid=1, in_data=0x33 → next cycle out_valid=0, out_data=0x00, occupancy=0. 0x33 never appears; stall_cnt unchanged.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles → stall_cnt reads 15 and stays 15.
- Random: 10k cycles with random in_valid/out_ready/flush (5%) against a scoreboard → output sequence equals input sequence minus flushed entries; out_data stable while stalled.

Source files
------------

// File: rtl/idex_skid_stage_pkg.sv
// Shared definitions for the ID/EX skid stage.
// Holds the state encodings and the ID->EX bundle layout.
package idex_skid_stage_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY   = 2'd0,
        SKID_BUSY    = 2'd1,
        SKID_FULL    = 2'd2,
        SKID_ILLEGAL = 2'd3
    } skid_state_e;

    localparam int IDEX_BUNDLE_W = 113;

    // Field offsets used by id/ex to pack and unpack the bundle
    localparam int LINK_LSB   = 0;
    localparam int WE_BIT     = 32;
    localparam int WADDR_LSB  = 33;
    localparam int OP2_LSB    = 38;
    localparam int OP1_LSB    = 70;
    localparam int ALUSEL_LSB = 102;
    localparam int ALUOP_LSB  = 105;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] link_addr;
    } idex_bundle_t;

    function automatic logic [1:0] skid_occ(input skid_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        if (s == SKID_BUSY) occ = 2'd1;
        if (s == SKID_FULL) occ = 2'd2;
        return occ;
    endfunction

endpackage

// File: rtl/idex_skid_stage.sv
// ID->EX pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// Payload is opaque; in_ready and all outputs are decoded from flops.
module idex_skid_stage
    import idex_skid_stage_pkg::*;
#(
    parameter int               WIDTH     = IDEX_BUNDLE_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic [CNT_W-1:0] r_stall;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_ready  = (r_state == SKID_EMPTY) || (r_state == SKID_BUSY);
    assign w_out_valid = (r_state == SKID_BUSY) || (r_state == SKID_FULL);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = SKID_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = SKID_BUSY;
                        w_main_nxt  = in_data;
                    end
                end
                SKID_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = SKID_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = SKID_EMPTY;
                        w_main_nxt  = NOP_VALUE;
                    end
                end
                SKID_FULL: begin
                    // skid is always the younger entry, so it moves up
                    if (w_out_fire) begin
                        w_state_nxt = SKID_BUSY;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = NOP_VALUE;
                    end
                end
                SKID_ILLEGAL: begin
                    w_state_nxt = SKID_EMPTY;
                    w_main_nxt  = NOP_VALUE;
                    w_skid_nxt  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = skid_occ(r_state);
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: directed vectors plus a queue scoreboard
// monitor that follows accepted entries and checks every cycle.
module tb_idex_skid_stage;

    localparam int W       = 8;
    localparam int CW      = 4;
    localparam int SAT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] sb[$];
    int           exp_stall = 0;

    idex_skid_stage #(
        .WIDTH    (W),
        .NOP_VALUE({W{1'b0}}),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    endtask

    // Scoreboard monitor: sb holds the entries the stage should hold,
    // oldest first; inputs are sampled mid-cycle ahead of the next edge.
    always @(negedge clk) begin
        int n;
        if (mon_en) begin
            n = sb.size();
            chk("sb_out_valid", 32'(out_valid), 32'(n > 0));
            chk("sb_in_ready", 32'(in_ready), 32'(n < 2));
            chk("sb_occupancy", 32'(occupancy), 32'(n));
            chk("sb_out_data", 32'(out_data), (n > 0) ? 32'(sb[0]) : 32'h0);
            chk("sb_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
            if (rst) begin
                sb.delete();
                exp_stall = 0;
            end else begin
                if (n > 0 && !out_ready && exp_stall < SAT_MAX)
                    exp_stall++;
                if (flush) begin
                    sb.delete();
                end else begin
                    if (n > 0 && out_ready) void'(sb.pop_front());
                    if (in_valid && n < 2) sb.push_back(in_data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAB;
        out_ready = 1'b0;
        step(1);
        mon_en = 1'b1;
        step(1);
        chk_reset_state();

        // streaming at full rate
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step(1);
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_occ", 32'(occupancy), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step(1);
        chk("stream_drain_occ", 32'(occupancy), 32'd0);

        // back-pressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step(1);
        chk("bp_first", 32'(out_data), 32'h11);
        in_data = 8'h22;
        step(1);
        chk("bp_occ_full", 32'(occupancy), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stall1", 32'(stall_cnt), 32'd1);
        in_valid = 1'b0;
        step(2);
        chk("bp_stable", 32'(out_data), 32'h11);
        chk("bp_stall3", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        step(1);
        chk("bp_second", 32'(out_data), 32'h22);
        chk("bp_occ_busy", 32'(occupancy), 32'd1);
        step(1);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);

        // flush while full, with a transfer offered the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        step(1);
        in_data = 8'h55;
        step(1);
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        flush     = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b1;
        step(1);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data", 32'(out_data), 32'h00);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_stall", 32'(stall_cnt), 32'd4);
        flush    = 1'b0;
        in_valid = 1'b0;
        step(3);
        chk("fl_no_ghost", 32'(out_valid), 32'd0);

        // saturation of the stall counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        step(1);
        in_data = 8'h77;
        step(1);
        in_valid = 1'b0;
        step(20);
        chk("sat_15", 32'(stall_cnt), 32'd15);
        step(3);
        chk("sat_hold", 32'(stall_cnt), 32'd15);
        chk("sat_data", 32'(out_data), 32'h66);

        // reset mid-operation while full
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAB;
        step(2);
        chk_reset_state();
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(1));
            flush     = ($urandom_range(99) < 5);
            step(1);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step(3);
        chk("final_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
